// File: rtl/rd_arbiter.sv
// Round-robin arbiter for a shared memory read port.
// Grants one requester per transaction, with wait-state retry and abort.
module rd_arbiter #(
  parameter int N        = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ws,
  output logic [N-1:0] gnt,
  output logic         rd,
  output logic         ds,
  output logic [N-1:0] done,
  output logic         err,
  output logic         busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    S1,
    S2,
    DONE,
    ERR
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] pick;
  logic          found;
  logic [WW-1:0] wait_cnt;
  logic [PW:0]   idx;

  // First set request searching cyclically upward from ptr.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // Transaction sequencer: grant, strobe, retry on wait, release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      win      <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          gnt <= '0;
          if (found) begin
            state    <= S1;
            gnt      <= N'(1) << pick;
            win      <= pick;
            wait_cnt <= '0;
          end
        end
        S1: state <= S2;
        S2: begin
          if (!ws) begin
            state <= DONE;
          end else if (wait_cnt < WW'(MAX_WAIT)) begin
            state    <= S1;
            wait_cnt <= wait_cnt + WW'(1);
          end else begin
            state <= ERR;
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          gnt   <= '0;
          ptr   <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign rd   = (state == S1) || (state == S2);
  assign ds   = (state == DONE);
  assign err  = (state == ERR);
  assign done = (state == DONE) ? gnt : '0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rd_arbiter.sv
// Testbench for rd_arbiter: scenario tasks plus a completion scoreboard.
// Completions (done or err) are checked against queued expectations.
module tb_rd_arbiter;

  localparam int N  = 4;
  localparam int MW = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         ws;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         rd;
  logic         ds;
  logic         err;
  logic         busy;

  typedef struct packed {
    logic [N-1:0] d;
    logic         e;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  rd_arbiter #(.N(N), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .ws  (ws),
    .gnt (gnt),
    .rd  (rd),
    .ds  (ds),
    .done(done),
    .err (err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // One cycle: sample after the edge, check invariants, drain scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    if (!$onehot0(gnt)) begin
      bad++;
      $display("FAIL onehot: gnt=%b", gnt);
    end
    total++;
    if (!busy && gnt !== '0) begin
      bad++;
      $display("FAIL idle_gnt: gnt=%b expected 0", gnt);
    end
    if (ds || err) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: ds=%b err=%b done=%b", ds, err, done);
      end else begin
        e = sbq.pop_front();
        if ({ds, done, err} !== {!e.e, e.d, e.e}) begin
          bad++;
          $display("FAIL sb_completion: ds/done/err=%b/%b/%b expected %b/%b/%b",
                   ds, done, err, !e.e, e.d, e.e);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    ws  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    ws  = 1'b0;
    tick();
    total++;
    if ({gnt, done, rd, ds, err, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outs: gnt=%b done=%b rd=%b ds=%b err=%b busy=%b expected 0",
               gnt, done, rd, ds, err, busy);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({gnt, done, rd, ds, err, busy} !== '0) begin
      bad++;
      $display("FAIL post_reset_outs: gnt=%b done=%b rd=%b ds=%b err=%b busy=%b expected 0",
               gnt, done, rd, ds, err, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_req: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    sbq.push_back({4'b0001, 1'b0});
    req = 4'b0001;
    tick();
    total++;
    if ({gnt, rd, busy} !== {4'b0001, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL single_c1: gnt=%b rd=%b busy=%b expected 0001 1 1", gnt, rd, busy);
    end
    tick();
    total++;
    if ({gnt, rd} !== {4'b0001, 1'b1}) begin
      bad++;
      $display("FAIL single_c2: gnt=%b rd=%b expected 0001 1", gnt, rd);
    end
    tick();
    total++;
    if ({gnt, rd, ds, done} !== {4'b0001, 1'b0, 1'b1, 4'b0001}) begin
      bad++;
      $display("FAIL single_c3: gnt=%b rd=%b ds=%b done=%b expected 0001 0 1 0001",
               gnt, rd, ds, done);
    end
    req = '0;
    tick();
    total++;
    if ({busy, gnt, done} !== '0) begin
      bad++;
      $display("FAIL single_c4: busy=%b gnt=%b done=%b expected 0", busy, gnt, done);
    end
  endtask

  task automatic test_rotate();
    logic [N-1:0] g;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      g = N'(1) << (k % N);
      sbq.push_back({g, 1'b0});
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = N'(1) << (k % N);
      tick();
      total++;
      if (gnt !== g) begin
        bad++;
        $display("FAIL rotate_gnt%0d: gnt=%b expected %b", k, gnt, g);
      end
      tick();
      tick();
      if (k == 4) req = '0;
      tick();
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL rotate_idle%0d: busy=%b expected 0", k, busy);
      end
    end
  endtask

  task automatic test_wait();
    int rdn = 0;
    do_reset();
    sbq.push_back({4'b0100, 1'b0});
    req = 4'b0100;
    ws  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (rd) rdn++;
      if (c == 5) ws = 1'b0;
      if (c == 7) begin
        total++;
        if ({ds, done} !== {1'b1, 4'b0100}) begin
          bad++;
          $display("FAIL wait_done: ds=%b done=%b expected 1 0100", ds, done);
        end
        req = '0;
      end
    end
    total++;
    if (rdn != 6) begin
      bad++;
      $display("FAIL wait_rd_cycles: got %0d expected 6", rdn);
    end
  endtask

  task automatic test_abort();
    int rdn  = 0;
    int errc = -1;
    do_reset();
    sbq.push_back({4'b0000, 1'b1});
    req = 4'b0010;
    ws  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (rd) rdn++;
      if (err) begin
        errc = c;
        break;
      end
    end
    req = '0;
    ws  = 1'b0;
    total++;
    if (errc != 33) begin
      bad++;
      $display("FAIL abort_err_cycle: got %0d expected 33", errc);
    end
    total++;
    if (rdn != 32) begin
      bad++;
      $display("FAIL abort_rd_cycles: got %0d expected 32", rdn);
    end
    tick();
    total++;
    if ({err, busy} !== 2'b00) begin
      bad++;
      $display("FAIL abort_after: err=%b busy=%b expected 0 0", err, busy);
    end
    sbq.push_back({4'b0100, 1'b0});
    req = 4'b1111;
    tick();
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL abort_next_gnt: gnt=%b expected 0100", gnt);
    end
    tick();
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    ws  = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL rmid_gnt: gnt=%b expected 1000", gnt);
    end
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({gnt, busy, done, ds} !== '0) begin
      bad++;
      $display("FAIL rmid_abort: gnt=%b busy=%b done=%b ds=%b expected 0",
               gnt, busy, done, ds);
    end
    rst = 1'b0;
    req = '0;
    ws  = 1'b0;
    tick();
    sbq.push_back({4'b0001, 1'b0});
    req = 4'b1111;
    tick();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL rmid_ptr: gnt=%b expected 0001", gnt);
    end
    tick();
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    sbq.push_back({4'b0001, 1'b0});
    req = 4'b0001;
    tick();
    tick();
    tick();
    req = '0;
    tick();
    sbq.push_back({4'b0010, 1'b0});
    sbq.push_back({4'b0001, 1'b0});
    req = 4'b0011;
    tick();
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL drop_first: gnt=%b expected 0010", gnt);
    end
    req = 4'b0001;
    tick();
    tick();
    total++;
    if (done !== 4'b0010) begin
      bad++;
      $display("FAIL drop_done: done=%b expected 0010", done);
    end
    tick();
    tick();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL drop_next: gnt=%b expected 0001", gnt);
    end
    tick();
    tick();
    total++;
    if (done !== 4'b0001) begin
      bad++;
      $display("FAIL drop_next_done: done=%b expected 0001", done);
    end
    req = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    ws  = 1'b0;
    test_reset();
    test_single();
    test_rotate();
    test_wait();
    test_abort();
    test_reset_mid();
    test_drop();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d pending expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
